// File: rtl/fk_history_seq_pkg.sv
// Shared filter definitions: history width, tap-select encodings used by the fk mux,
// and the tap sequencer state encoding.
package fk_history_seq_pkg;

  localparam int WIDTH_DEFAULT = 25;

  localparam logic [1:0] SEL_FK   = 2'b00;
  localparam logic [1:0] SEL_FK1  = 2'b01;
  localparam logic [1:0] SEL_FK2  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    TAP0  = 3'd2,
    TAP1  = 3'd3,
    TAP2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Only the TAP states route a real sample into the accumulator.
  function automatic logic [1:0] select_for(input state_t s);
    case (s)
      TAP0:    return SEL_FK;
      TAP1:    return SEL_FK1;
      TAP2:    return SEL_FK2;
      default: return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/fk_history_seq.sv
// Three-sample fk history plus the serial tap sequencer that drives the shared
// multiplier/accumulator through fk, fk_1 and fk_2 once per accepted sample.
module fk_history_seq
  import fk_history_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             flush,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] fk,
  output logic [WIDTH-1:0] fk_1,
  output logic [WIDTH-1:0] fk_2,
  output logic [1:0]       select,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_t state, state_nxt;
  logic   accept;
  logic   clear_hist;
  logic   overrun_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    clear_hist  = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          accept    = 1'b1;
          state_nxt = CLEAR;
        end else if (flush) begin
          clear_hist = 1'b1;
        end
      end
      CLEAR:   state_nxt = TAP0;
      TAP0:    state_nxt = TAP1;
      TAP1:    state_nxt = TAP2;
      TAP2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && sample_valid) overrun_set = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      select  <= SEL_ZERO;
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      select  <= select_for(state_nxt);
      acc_clr <= (state_nxt == CLEAR);
      acc_en  <= (state_nxt == TAP0) || (state_nxt == TAP1) || (state_nxt == TAP2);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fk   <= '0;
      fk_1 <= '0;
      fk_2 <= '0;
    end else if (accept) begin
      fk_2 <= fk_1;
      fk_1 <= fk;
      fk   <= sample_in;
    end else if (clear_hist) begin
      fk   <= '0;
      fk_1 <= '0;
      fk_2 <= '0;
    end
  end

  // A fresh overrun wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (overrun_set) overrun <= 1'b1;
    else if (clr_ovr)     overrun <= 1'b0;
  end

endmodule

// File: doc/fk_history_seq.md
Name: fk_history_seq

Overview:
- Upstream stage of the fk tap multiplexer in the filter datapath.
- Holds the three-sample history fk, fk_1 and fk_2 of the filter state signal.
- On each new sample it shifts the history, then steps the 2-bit mux select through a fixed tap sequence so one multiplier/accumulator handles all taps serially.
- Emits accumulator control strobes and a done pulse per sample.

Parameters:
- WIDTH, 25: bit width of each history word (signed fixed-point; not interpreted by this block).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sample_in  input  WIDTH  new fk value.
- sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
- flush  input  1  synchronous clear of history; honoured only in IDLE.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- fk  output  WIDTH  newest sample, registered.
- fk_1  output  WIDTH  previous sample, registered.
- fk_2  output  WIDTH  sample before fk_1, registered.
- select  output  2  tap select to the mux: 00=fk, 01=fk_1, 10=fk_2, 11=zero.
- acc_clr  output  1  clear accumulator this cycle.
- acc_en  output  1  accumulate the mux output this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the tap sequence completes.
- overrun  output  1  sticky; a sample_valid arrived while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - fk, fk_1, fk_2 = 0; select = 2'b11.
  - acc_clr, acc_en, busy, done, overrun = 0; state = IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, CLEAR, TAP0, TAP1, TAP2, DONE.
- IDLE:
  - select=11, acc_en=0, busy=0.
  - On sample_valid: fk_2<=fk_1, fk_1<=fk, fk<=sample_in in one edge; go to CLEAR.
  - Else, on flush: fk, fk_1, fk_2 <= 0; stay in IDLE.
  - sample_valid has priority over flush.
- CLEAR: select=11, acc_clr=1, acc_en=0; go to TAP0.
- TAP0: select=00, acc_en=1; go to TAP1.
- TAP1: select=01, acc_en=1; go to TAP2.
- TAP2: select=10, acc_en=1; go to DONE.
- DONE: select=11, done=1, acc_en=0; go to IDLE.
- Timing: sample_valid in cycle N gives the history update visible in N+1 and done high in cycle N+5. Minimum sample spacing is 6 cycles: a strobe in the cycle after DONE is accepted.
- History registers change only on an accepted sample or a flush. They are stable from CLEAR through DONE.
- sample_valid while busy:
  - The sample is dropped and history is unchanged.
  - overrun<=1.
  - The sequence continues undisturbed.
- overrun clears only on clr_ovr. If clr_ovr and a new overrun occur in the same cycle, overrun stays 1.
- flush while busy is ignored (no effect, no flag).
- Reset asserted mid-sequence: everything returns to reset values immediately. No done pulse is emitted for the aborted sample.
- The select value 11 outputs zero from the mux. It is driven in every non-TAP state so the accumulator input is 0 outside TAP0..TAP2.
- Values are stored bit-exact. No arithmetic, sign extension or saturation in this block.

Decomposition:
- Shared filter package:
  - WIDTH default.
  - select encodings SEL_FK=2'b00, SEL_FK1=2'b01, SEL_FK2=2'b10, SEL_ZERO=2'b11, shared with the mux.
  - FSM state encoding.
- No sub-module is needed. History registers and FSM sit in one module. The mux stays a separate, existing stage.

Test Plan:
- Reset then idle: release reset, hold inputs 0 for 10 cycles -> all outputs 0, select=11, busy=0.
- Three samples 25'h0000011, 25'h0000022, 25'h0000033, each spaced 6 cycles -> after the third, fk=33, fk_1=22, fk_2=11. Per sample, select sequence is 11,11,00,01,10,11; acc_clr in CLEAR only; acc_en for 3 cycles; done at N+5.
- Overrun: sample_valid at N, second strobe at N+2 with 25'h1FFFFFF -> history keeps the first sample, overrun=1 stays set; clr_ovr pulse -> overrun=0.
- Back-to-back: strobe at N and N+6 -> both accepted; done at N+5 and N+11; overrun=0.
- Flush: with history loaded, flush in IDLE -> fk, fk_1, fk_2 = 0 next cycle. Flush during TAP1 -> history unchanged. sample_valid+flush together in IDLE -> sample shifted in, no clear.
- Reset mid-sequence: assert reset during TAP1 -> outputs zero asynchronously, no done. After release, a new sample runs the full sequence normally.
